// File: rtl/d_bch_dec_parallel_remainder_checker.sv
// BCH decoder head: divides a received codeword by g(x), P_LVL bits per cycle, reports remainder and error flag.
// Latency: result (o_done, o_remainder, o_err_detected) valid the cycle after the last chunk is accepted.
// Backpressure: o_data_ready high only while a codeword is in progress; optional error counter via D_BCH_DEC_ERR_CNT_EN.
module d_bch_dec_parallel_remainder_checker #(
  parameter int                    P_LVL      = 8,
  parameter int                    MSG_LENGTH = 8192,
  parameter int                    PRT_LENGTH = 168,
  parameter logic [PRT_LENGTH-1:0] G_POLY     = '0
) (
  input  logic                  i_clk,
  input  logic                  i_nRESET,
  input  logic                  i_start,
  input  logic                  i_data_valid,
  input  logic [P_LVL-1:0]      i_data,
  output logic                  o_data_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PRT_LENGTH-1:0] o_remainder,
  output logic                  o_err_detected,
  output logic [15:0]           o_err_cw_cnt
);

  localparam int CHUNKS = (MSG_LENGTH + PRT_LENGTH) / P_LVL;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PRT_LENGTH-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PRT_LENGTH-1:0]   rem_step;
  logic                    accept;
  logic                    start_clr;
  logic                    last_chunk;

  // A start is only honoured outside RUN; an in-flight codeword is never disturbed.
  assign accept     = i_data_valid && (state_q == S_RUN);
  assign start_clr  = i_start && (state_q != S_RUN);
  assign last_chunk = (cnt_q == LAST_CHUNK);

  // P_LVL serial LFSR division steps, earliest (highest-order) bit first.
  always_comb begin
    logic [P_LVL-1:0] data_sh;
    logic             fb;
    rem_step = rem_q;
    data_sh  = i_data;
    for (int j = 0; j < P_LVL; j++) begin
      fb       = rem_step[PRT_LENGTH-1];
      rem_step = {rem_step[PRT_LENGTH-2:0], data_sh[P_LVL-1]} ^ (fb ? G_POLY : '0);
      data_sh  = data_sh << 1;
    end
  end

  // Next-state and datapath update selection.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (start_clr) begin
      rem_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      rem_d = rem_step;
      // Counter parks on the final chunk index rather than wrapping.
      if (!last_chunk) cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (accept && last_chunk) state_d = S_DONE;
      S_DONE:  state_d = i_start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, remainder and chunk-count registers.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  // Remainder is held in rem_q until the next accepted start, so it doubles as the result.
  assign o_data_ready   = (state_q == S_RUN);
  assign o_busy         = (state_q == S_RUN);
  assign o_done         = (state_q == S_DONE);
  assign o_remainder    = rem_q;
  assign o_err_detected = |rem_q;

`ifdef D_BCH_DEC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count erroneous codewords on the done cycle; saturate, clear only on reset.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_DONE) && (|rem_q) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error-codeword counter register.
  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) err_cnt_q <= '0;
    else           err_cnt_q <= err_cnt_d;
  end

  assign o_err_cw_cnt = err_cnt_q;
`else
  assign o_err_cw_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_d_bch_dec_parallel_remainder_checker.sv
// Bench for the parallel BCH remainder checker with g(x)=x^4+x+1, 4 bits/cycle, 3 chunks per codeword.
module tb_d_bch_dec_parallel_remainder_checker;

  logic        i_clk = 1'b0;
  logic        i_nRESET;
  logic        i_start;
  logic        i_data_valid;
  logic [3:0]  i_data;
  logic        o_data_ready;
  logic        o_busy;
  logic        o_done;
  logic [3:0]  o_remainder;
  logic        o_err_detected;
  logic [15:0] o_err_cw_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'h0;

  typedef struct {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [3:0] rem;
    logic       err;
  } vec_t;

  vec_t tbl[8];

  d_bch_dec_parallel_remainder_checker #(
    .P_LVL(4), .MSG_LENGTH(8), .PRT_LENGTH(4), .G_POLY(4'b0011)
  ) dut (
    .i_clk(i_clk), .i_nRESET(i_nRESET), .i_start(i_start),
    .i_data_valid(i_data_valid), .i_data(i_data),
    .o_data_ready(o_data_ready), .o_busy(o_busy), .o_done(o_done),
    .o_remainder(o_remainder), .o_err_detected(o_err_detected),
    .o_err_cw_cnt(o_err_cw_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ready"}, {31'b0, o_data_ready}, 0);
    chk({nm, " busy"},  {31'b0, o_busy}, 0);
    chk({nm, " done"},  {31'b0, o_done}, 0);
    chk({nm, " rem"},   {28'b0, o_remainder}, 0);
    chk({nm, " err"},   {31'b0, o_err_detected}, 0);
    chk({nm, " cnt"},   {16'b0, o_err_cw_cnt}, 0);
  endtask

  // Start a codeword (i_start driven during whatever state precedes), feed three chunks.
  task automatic run_cw(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                        input int gap, input bit mid_start, input bit pulse_chk,
                        input logic [3:0] erem, input logic eerr, input string nm);
    logic [3:0] ch[3];
    ch[0] = c0; ch[1] = c1; ch[2] = c2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk({nm, " ready_after_start"}, {31'b0, o_data_ready}, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          i_data_valid = 1'b0;
          i_start = mid_start && (g == 0);
          tick();
          i_start = 1'b0;
          chk({nm, " busy_in_gap"}, {31'b0, o_busy}, 1);
        end
      end
      i_data_valid = 1'b1;
      i_data = ch[k];
      tick();
      i_data_valid = 1'b0;
      i_data = 4'h0;
      if (k < 2) chk({nm, " no_early_done"}, {31'b0, o_done}, 0);
    end
    chk({nm, " done"}, {31'b0, o_done}, 1);
    chk({nm, " rem"},  {28'b0, o_remainder}, {28'b0, erem});
    chk({nm, " err"},  {31'b0, o_err_detected}, {31'b0, eerr});
    chk({nm, " busy_at_done"}, {31'b0, o_busy}, 0);
`ifdef D_BCH_DEC_ERR_CNT_EN
    if (eerr && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
    if (pulse_chk) begin
      tick();
      chk({nm, " done_pulse"}, {31'b0, o_done}, 0);
      chk({nm, " rem_hold"},   {28'b0, o_remainder}, {28'b0, erem});
      chk({nm, " err_hold"},   {31'b0, o_err_detected}, {31'b0, eerr});
      chk({nm, " cnt"},        {16'b0, o_err_cw_cnt}, {16'b0, exp_cnt});
    end
  endtask

  initial begin
    // Hand-computed remainders mod x^4+x+1 (x^4=3, x^8=5, x^11=E).
    tbl[0] = '{c0: 4'h0, c1: 4'h1, c2: 4'h3, rem: 4'h0, err: 1'b0};
    tbl[1] = '{c0: 4'h0, c1: 4'h0, c2: 4'h3, rem: 4'h3, err: 1'b1};
    tbl[2] = '{c0: 4'h0, c1: 4'h0, c2: 4'h1, rem: 4'h1, err: 1'b1};
    tbl[3] = '{c0: 4'h0, c1: 4'h1, c2: 4'h0, rem: 4'h3, err: 1'b1};
    tbl[4] = '{c0: 4'h1, c1: 4'h0, c2: 4'h0, rem: 4'h5, err: 1'b1};
    tbl[5] = '{c0: 4'h8, c1: 4'h0, c2: 4'h0, rem: 4'hE, err: 1'b1};
    tbl[6] = '{c0: 4'hF, c1: 4'hF, c2: 4'hF, rem: 4'hB, err: 1'b1};
    tbl[7] = '{c0: 4'h0, c1: 4'h1, c2: 4'h2, rem: 4'h1, err: 1'b1};

    i_nRESET = 1'b0;
    i_start = 1'b0;
    i_data_valid = 1'b0;
    i_data = 4'h0;
    #2;
    chk_all_zero("reset_state");
    tick();
    tick();
    i_nRESET = 1'b1;
    tick();
    chk_all_zero("idle_after_reset");

    // Reset asserted mid-codeword discards the partial result.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_data_valid = 1'b1;
    i_data = 4'hF;
    tick();
    i_data_valid = 1'b0;
    i_nRESET = 1'b0;
    #1;
    chk_all_zero("reset_mid_run");
    tick();
    chk_all_zero("reset_held");
    i_nRESET = 1'b1;
    tick();
    chk({"post_reset ready"}, {31'b0, o_data_ready}, 0);
    chk({"post_reset busy"},  {31'b0, o_busy}, 0);

    // Table of codewords; odd entries start on the previous done cycle.
    for (int i = 0; i < 8; i++) begin
      run_cw(tbl[i].c0, tbl[i].c1, tbl[i].c2, 0, 1'b0, (i % 2) == 1,
             tbl[i].rem, tbl[i].err, $sformatf("vec%0d", i));
    end

    // Idle gaps between chunks plus an ignored mid-run start.
    run_cw(4'h0, 4'h1, 4'h3, 2, 1'b1, 1'b1, 4'h0, 1'b0, "gap_midstart");
    run_cw(4'h0, 4'h0, 4'h3, 2, 1'b1, 1'b1, 4'h3, 1'b1, "gap_midstart_err");

    // Start on the done cycle: clean codeword then a corrupted one, and the reverse.
    run_cw(4'h0, 4'h1, 4'h3, 0, 1'b0, 1'b0, 4'h0, 1'b0, "b2b_first");
    run_cw(4'h0, 4'h0, 4'h3, 0, 1'b0, 1'b1, 4'h3, 1'b1, "b2b_second");
    run_cw(4'h0, 4'h0, 4'h3, 0, 1'b0, 1'b0, 4'h3, 1'b1, "b2b_err_first");
    run_cw(4'h0, 4'h1, 4'h3, 0, 1'b0, 1'b1, 4'h0, 1'b0, "b2b_clean_second");

`ifdef D_BCH_DEC_ERR_CNT_EN
    // Counter saturation.
    force dut.err_cnt_q = 16'hFFFF;
    tick();
    release dut.err_cnt_q;
    exp_cnt = 16'hFFFF;
    run_cw(4'h0, 4'h0, 4'h3, 0, 1'b0, 1'b1, 4'h3, 1'b1, "cnt_saturate");
`endif

    tick();
    chk("final_idle busy", {31'b0, o_busy}, 0);
    chk("final_idle done", {31'b0, o_done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
